// File: rtl/nonce_scheduler_if.sv
// Bundle of the scheduler's handshake, core-dispatch and memory-write signals.
// "master" is the scheduler side; "slave" is the environment driving start,
// the engine results and receiving the memory writes.
interface nonce_scheduler_if #(
    parameter int NUM_CORES = 4
);
    logic                      start;
    logic [15:0]               output_addr;
    logic                      done;
    logic [NUM_CORES-1:0]      core_start;
    logic [31:0]               core_nonce;
    logic [NUM_CORES-1:0]      core_done;
    logic [32*NUM_CORES-1:0]   core_h0;
    logic                      mem_we;
    logic [15:0]               mem_addr;
    logic [31:0]               mem_write_data;

    modport master (
        input  start, output_addr, core_done, core_h0,
        output done, core_start, core_nonce, mem_we, mem_addr, mem_write_data
    );

    modport slave (
        output start, output_addr, core_done, core_h0,
        input  done, core_start, core_nonce, mem_we, mem_addr, mem_write_data
    );
endinterface

// File: rtl/nonce_scheduler.sv
// Nonce scheduler: hands nonces 0..NUM_OF_NONCES-1 to the lowest idle hash
// engine, captures each engine's h0 result, and writes it to memory at
// base + nonce. One dispatch and one write at most per cycle; the batch ends
// on the edge that issues the last write.
module nonce_scheduler #(
    parameter int NUM_CORES     = 4,
    parameter int NUM_OF_NONCES = 16
) (
    input  logic             clk,
    input  logic             reset,
    nonce_scheduler_if.master bus
);
    localparam int CW = $clog2(NUM_OF_NONCES + 1);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [CW-1:0] BATCH_LEN = CW'(NUM_OF_NONCES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [15:0]          base;
    logic [CW-1:0]        next_nonce;
    logic [CW-1:0]        written;
    logic [NUM_CORES-1:0] busy;
    logic [NUM_CORES-1:0] pend;
    logic [31:0]          res [NUM_CORES];
    logic [CW-1:0]        tag [NUM_CORES];

    logic [NUM_CORES-1:0] idle;
    logic                 disp_ok;
    logic [IW-1:0]        disp_idx;
    logic                 wr_ok;
    logic [IW-1:0]        wr_idx;

    // Priority pick of the lowest idle core (dispatch) and lowest pending core (write).
    always_comb begin
        idle     = ~busy & ~pend;
        disp_ok  = 1'b0;
        disp_idx = '0;
        wr_ok    = 1'b0;
        wr_idx   = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (idle[k]) begin
                disp_ok  = 1'b1;
                disp_idx = IW'(k);
            end
            if (pend[k]) begin
                wr_ok  = 1'b1;
                wr_idx = IW'(k);
            end
        end
    end

    // Two-state controller with dispatch, capture and write running in parallel in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            base               <= '0;
            next_nonce         <= '0;
            written            <= '0;
            busy               <= '0;
            pend               <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                res[k] <= '0;
                tag[k] <= '0;
            end
            bus.done           <= 1'b1;
            bus.core_start     <= '0;
            bus.core_nonce     <= '0;
            bus.mem_we         <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.core_start <= '0;
                    bus.mem_we     <= 1'b0;
                    bus.done       <= 1'b1;
                    if (bus.start) begin
                        base       <= bus.output_addr;
                        next_nonce <= '0;
                        written    <= '0;
                        busy       <= '0;
                        pend       <= '0;
                        bus.done   <= 1'b0;
                        state      <= RUN;
                    end
                end

                RUN: begin
                    bus.core_start <= '0;
                    bus.mem_we     <= 1'b0;

                    // A dispatched core is idle, so it can never be capturing this edge.
                    if (disp_ok && (next_nonce < BATCH_LEN)) begin
                        bus.core_start[disp_idx] <= 1'b1;
                        bus.core_nonce           <= 32'(next_nonce);
                        busy[disp_idx]           <= 1'b1;
                        tag[disp_idx]            <= next_nonce;
                        next_nonce               <= next_nonce + 1'b1;
                    end

                    // Results from cores that were not dispatched are dropped.
                    for (int k = 0; k < NUM_CORES; k++) begin
                        if (bus.core_done[k] && busy[k]) begin
                            res[k]  <= bus.core_h0[32*k +: 32];
                            pend[k] <= 1'b1;
                            busy[k] <= 1'b0;
                        end
                    end

                    // Address arithmetic is 16-bit and wraps.
                    if (wr_ok) begin
                        bus.mem_we         <= 1'b1;
                        bus.mem_addr       <= base + 16'(tag[wr_idx]);
                        bus.mem_write_data <= res[wr_idx];
                        pend[wr_idx]       <= 1'b0;
                        written            <= written + 1'b1;
                        if ((written + 1'b1) == BATCH_LEN) begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: model hash cores reply after a configurable
// latency with h0 = 0xA5000000 | nonce; a behavioural model of the dispatch
// and write rules is checked against the DUT every cycle.
module tb_nonce_scheduler;
    localparam int NC = 4;
    localparam int NN = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nonce_scheduler_if #(.NUM_CORES(NC)) bus ();

    nonce_scheduler #(.NUM_CORES(NC), .NUM_OF_NONCES(NN)) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // core model
    int          mode;
    logic [NC-1:0] spur;
    int          due      [NC];
    logic [31:0] cm_nonce [NC];

    // reference model: state of the scheduler as the rules define it
    bit          st_last;      // 1 = running during the previous cycle
    bit          start_prev;
    logic [15:0] addr_prev;
    bit          inuse [NC];   // dispatched and not yet written
    int          mnonce[NC];
    int          deliv [NC];   // cycle the result was captured, -1 if none
    logic [31:0] mres  [NC];
    int          issued, written;
    logic [15:0] mbase;

    // per-batch records
    int          wr_cnt;
    int          seen       [NN];
    int          wr_cyc_of  [NN];
    logic [15:0] wr_addr_of [NN];
    logic [31:0] wr_data_of [NN];
    int          disp_cyc_of [NN];
    int          disp_core_of[NN];
    int          last_we_cyc, done_rise_cyc;
    bit          batch_fin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input int k);
        if (mode == 1) return int'($urandom_range(1, 12));
        if (mode == 2) return 10 + (3 - k);
        return 10;
    endfunction

    task automatic clear_records();
        wr_cnt = 0; batch_fin = 0; last_we_cyc = -1; done_rise_cyc = -1;
        for (int n = 0; n < NN; n++) begin
            seen[n] = 0; wr_cyc_of[n] = -1; wr_addr_of[n] = 'x; wr_data_of[n] = 'x;
            disp_cyc_of[n] = -1; disp_core_of[n] = -1;
        end
    endtask

    // Compare the outputs of the current cycle with the model, then advance it.
    task automatic observe();
        bit acc, st_cur, exp_done;
        int dk, wk, n;
        logic [15:0] exp_addr;
        if (rst) begin
            st_last = 0; start_prev = 0;
            for (int k = 0; k < NC; k++) begin
                inuse[k] = 0; deliv[k] = -1; due[k] = -1;
            end
            return;
        end
        acc = !st_last && start_prev;
        if (acc) begin
            issued = 0; written = 0; mbase = addr_prev;
            for (int k = 0; k < NC; k++) begin
                inuse[k] = 0; deliv[k] = -1;
            end
            clear_records();
        end
        exp_done = !st_last && !acc;
        dk = -1;
        wk = -1;
        if (st_last) begin
            for (int k = NC - 1; k >= 0; k--) begin
                if (issued < NN && !inuse[k]) dk = k;
                if (inuse[k] && deliv[k] >= 0 && deliv[k] <= cyc - 2) wk = k;
            end
        end

        chk("done", 32'(bus.done), 32'(exp_done));
        chk("core_start", 32'(bus.core_start), (dk >= 0) ? (32'd1 << dk) : 32'd0);
        if (dk >= 0) chk("core_nonce", bus.core_nonce, 32'(issued));
        chk("mem_we", 32'(bus.mem_we), 32'(wk >= 0));
        if (wk >= 0) begin
            exp_addr = mbase + 16'(mnonce[wk]);
            chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
            chk("mem_write_data", bus.mem_write_data, mres[wk]);
        end
        if (bus.mem_we) wr_cnt++;

        for (int k = 0; k < NC; k++) begin
            if (bus.core_start[k]) begin
                due[k] = cyc + lat(k);
                cm_nonce[k] = bus.core_nonce;
            end
        end

        st_cur = acc ? 1'b1 : st_last;
        if (dk >= 0) begin
            inuse[dk] = 1; mnonce[dk] = issued; deliv[dk] = -1;
            disp_cyc_of[issued] = cyc; disp_core_of[issued] = dk;
            issued++;
        end
        if (wk >= 0) begin
            n = mnonce[wk];
            seen[n]++;
            wr_cyc_of[n] = cyc; wr_addr_of[n] = bus.mem_addr; wr_data_of[n] = bus.mem_write_data;
            inuse[wk] = 0;
            written++;
            if (written == NN) begin
                st_cur = 0; batch_fin = 1; last_we_cyc = cyc;
            end
        end
        if (st_cur) begin
            for (int k = 0; k < NC; k++) begin
                if (bus.core_done[k] && inuse[k] && deliv[k] < 0) begin
                    deliv[k] = cyc;
                    mres[k] = bus.core_h0[32*k +: 32];
                end
            end
        end
        if (batch_fin && done_rise_cyc < 0 && bus.done) done_rise_cyc = cyc;
        st_last = st_cur;
        start_prev = bus.start;
        addr_prev = bus.output_addr;
    endtask

    // One clock: check at the falling edge, drive core replies just after the rising edge.
    task automatic tick();
        logic [NC-1:0]    cd;
        logic [32*NC-1:0] h;
        bit hit;
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NC; k++) begin
            hit = !rst && (due[k] == cyc);
            cd[k] = hit | spur[k];
            h[32*k +: 32] = hit ? (32'hA500_0000 | cm_nonce[k]) : 32'($urandom);
        end
        bus.core_done = cd;
        bus.core_h0 = h;
    endtask

    int start_cyc;

    task automatic run_batch(input logic [15:0] b, input int md, input bit do_spur,
                             input bit do_restart, input int rst_after);
        bit fin;
        fin = 0;
        mode = md;
        bus.output_addr = b;
        bus.start = 1'b1;
        start_cyc = cyc;
        tick();
        bus.start = 1'b0;
        bus.output_addr = 16'($urandom);
        for (int i = 0; i < 3000 && !fin; i++) begin
            if (do_spur && i == 0) spur[2] = 1'b1;
            if (do_restart && i == 20) begin
                bus.start = 1'b1;
                bus.output_addr = 16'h1234;
            end
            tick();
            spur = '0;
            bus.start = 1'b0;
            if (rst_after > 0 && wr_cnt >= rst_after) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
                chk("rst_mid_done", 32'(bus.done), 32'd1);
                chk("rst_mid_core_start", 32'(bus.core_start), 32'd0);
                tick();
                tick();
                rst = 1'b0;
                tick();
                fin = 1;
            end else if (batch_fin && done_rise_cyc >= 0) begin
                fin = 1;
            end
        end
        if (!fin) chk("batch_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic check_full(input string tag);
        int ok;
        ok = 0;
        for (int n = 0; n < NN; n++) if (seen[n] == 1) ok++;
        chk({tag, "_write_count"}, 32'(wr_cnt), 32'(NN));
        chk({tag, "_each_once"}, 32'(ok), 32'(NN));
        chk({tag, "_done_after_last"}, 32'(done_rise_cyc - last_we_cyc), 32'd1);
    endtask

    initial begin
        int ordered;
        bus.start = 1'b0;
        bus.output_addr = '0;
        bus.core_done = '0;
        bus.core_h0 = '0;
        spur = '0;
        mode = 0;
        st_last = 0; start_prev = 0; addr_prev = '0;
        issued = 0; written = 0; mbase = '0;
        for (int k = 0; k < NC; k++) begin
            due[k] = -1; inuse[k] = 0; deliv[k] = -1; mnonce[k] = 0; mres[k] = '0; cm_nonce[k] = '0;
        end
        clear_records();

        // reset with no clock edge
        #1 rst = 1'b1;
        #1;
        chk("reset_done", 32'(bus.done), 32'd1);
        chk("reset_core_start", 32'(bus.core_start), 32'd0);
        chk("reset_core_nonce", bus.core_nonce, 32'd0);
        chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset_mem_write_data", bus.mem_write_data, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        // normal batch, fixed latency
        run_batch(16'h0100, 0, 0, 0, 0);
        check_full("normal");
        chk("normal_addr5", 32'(wr_addr_of[5]), 32'h0000_0105);
        chk("normal_data5", wr_data_of[5], 32'hA500_0005);
        chk("normal_data15", wr_data_of[15], 32'hA500_000F);
        chk("normal_first_dispatch", 32'(disp_cyc_of[0] - start_cyc), 32'd2);
        chk("normal_core3_nonce3", 32'(disp_core_of[3]), 32'd3);
        chk("normal_consec_start", 32'(disp_cyc_of[3] - disp_cyc_of[0]), 32'd3);
        ordered = 0;
        for (int n = 1; n < NN; n++) if (disp_cyc_of[n] > disp_cyc_of[n-1]) ordered++;
        chk("normal_issue_order", 32'(ordered), 32'(NN - 1));

        // all four cores complete in the same cycle
        run_batch(16'h2000, 2, 0, 0, 0);
        check_full("simul");
        chk("simul_w1", 32'(wr_cyc_of[1] - wr_cyc_of[0]), 32'd1);
        chk("simul_w2", 32'(wr_cyc_of[2] - wr_cyc_of[0]), 32'd2);
        chk("simul_w3", 32'(wr_cyc_of[3] - wr_cyc_of[0]), 32'd3);
        chk("simul_core3_redispatch", 32'(disp_cyc_of[7] - wr_cyc_of[3]), 32'd1);
        chk("simul_core3_nonce7", 32'(disp_core_of[7]), 32'd3);

        // address wrap
        run_batch(16'hFFF8, 1, 0, 0, 0);
        check_full("wrap");
        chk("wrap_addr0", 32'(wr_addr_of[0]), 32'h0000_FFF8);
        chk("wrap_addr8", 32'(wr_addr_of[8]), 32'h0000_0000);
        chk("wrap_addr15", 32'(wr_addr_of[15]), 32'h0000_0007);

        // spurious core_done and start re-pulsed mid-batch
        run_batch(16'h0400, 1, 1, 1, 0);
        check_full("robust");

        // reset after five writes, then a full batch
        run_batch(16'h0500, 1, 0, 0, 5);
        chk("abort_writes", 32'(wr_cnt), 32'd5);
        run_batch(16'h0100, 1, 0, 0, 0);
        check_full("after_reset");
        chk("after_reset_addr9", 32'(wr_addr_of[9]), 32'h0000_0109);

        // random batches
        for (int r = 0; r < 3; r++) begin
            run_batch(16'($urandom), 1, 0, 0, 0);
            check_full("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
